// File: rtl/i2s_audio_tx.sv
// I2S transmitter for the on-board DAC: volume scaling, optional mono mix,
// fixed attenuation, and Philips-framed 16-bit L/R slots on a divided bit clock.
module i2s_audio_tx #(
    parameter int BCK_HALF    = 18,
    parameter int STEREO      = 0,
    parameter int AUDIO_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] audio_l,
    input  logic [14:0] audio_r,
    input  logic [1:0]  volume,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        sample_strobe,
    output logic [15:0] dac
);

    localparam int DW = (BCK_HALF > 2) ? $clog2(BCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_HALF - 1);

    logic [DW-1:0]      div_cnt;
    logic               bck;
    logic [4:0]         bit_cnt;
    logic [4:0]         bit_next;
    logic [31:0]        shift_reg;
    logic               tick;
    logic               fall;
    logic               load;
    logic signed [15:0] xl, xr, vl, vr, mix, slot_l, slot_r;

    function automatic logic signed [15:0] apply_vol(input logic signed [15:0] x,
                                                     input logic [1:0] v);
        case (v)
            2'd0:    return '0;
            2'd1:    return x >>> 2;
            2'd2:    return x >>> 1;
            default: return x;
        endcase
    endfunction

    always_comb begin
        xl  = {audio_l[14], audio_l};
        xr  = {audio_r[14], audio_r};
        vl  = apply_vol(xl, volume);
        vr  = apply_vol(xr, volume);
        // Each term is within -16384..16383, so the 16-bit sum cannot overflow.
        mix = vl + vr;
        if (STEREO != 0) begin
            slot_l = vl >>> AUDIO_SHIFT;
            slot_r = vr >>> AUDIO_SHIFT;
        end else begin
            slot_l = mix >>> AUDIO_SHIFT;
            slot_r = mix >>> AUDIO_SHIFT;
        end
    end

    always_comb begin
        tick     = (div_cnt == DIV_LAST);
        fall     = tick & bck;
        load     = fall & (bit_cnt == 5'd31);
        bit_next = bit_cnt + 5'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            bck           <= 1'b0;
            bit_cnt       <= 5'd31;
            shift_reg     <= '0;
            hp_ws         <= 1'b0;
            sample_strobe <= 1'b0;
            dac           <= '0;
        end else begin
            sample_strobe <= load;
            if (tick) begin
                div_cnt <= '0;
                bck     <= ~bck;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (fall) begin
                bit_cnt <= bit_next;
                // WS leads each channel by one bit: high for bits 15..30.
                hp_ws   <= (bit_next >= 5'd15) && (bit_next <= 5'd30);
                if (load) begin
                    shift_reg <= {slot_l, slot_r};
                    dac       <= mix;
                end else begin
                    shift_reg <= {shift_reg[30:0], 1'b0};
                end
            end
        end
    end

    assign hp_bck = bck;
    assign hp_din = shift_reg[31];

endmodule
